// File: rtl/sr_cmd_if.sv
// Command handshake and SR drive bundle between a requester and sr_cmd_driver.
// The requester owns req_*; the driver owns everything else.
interface sr_cmd_if #(
    parameter int CNT_W = 8
);
    logic             req_valid;
    logic             req_set;
    logic             req_clr;
    logic             req_ready;
    logic             s;
    logic             r;
    logic             busy;
    logic             q_shadow;
    logic [CNT_W-1:0] conflict_cnt;

    // A command transfers on a rising edge where req_valid and req_ready are both high;
    // req_ready depends on driver state only, never on req_*.
    modport master (
        output req_valid, req_set, req_clr,
        input  req_ready, s, r, busy, q_shadow, conflict_cnt
    );

    modport slave (
        input  req_valid, req_set, req_clr,
        output req_ready, s, r, busy, q_shadow, conflict_cnt
    );
endinterface

// File: rtl/sr_cmd_driver.sv
// Turns set/clear commands into fixed-width one-hot pulses on s/r for an SR stage,
// followed by an idle gap; resolves set&clr by priority and counts such conflicts.
module sr_cmd_driver #(
    parameter int HOLD_CYC     = 2,
    parameter int GAP_CYC      = 1,
    parameter int RST_PRIORITY = 1,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    sr_cmd_if.slave    bus,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int MAXC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic          SET_WINS = (RST_PRIORITY == 0);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             s_q;
    logic             r_q;
    logic             q_shadow_q;
    logic [CNT_W-1:0] conflict_cnt_q;

    logic accept;
    logic is_cmd;
    logic conflict;
    logic dir_set;

    assign accept   = bus.req_valid && (state_q == IDLE);
    assign is_cmd   = bus.req_set || bus.req_clr;
    assign conflict = bus.req_set && bus.req_clr;
    // On conflict the priority parameter picks the direction; otherwise the single request does.
    assign dir_set  = conflict ? SET_WINS : bus.req_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            s_q            <= 1'b0;
            r_q            <= 1'b0;
            q_shadow_q     <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && is_cmd) begin
                        state_q    <= DRIVE;
                        cnt_q      <= HOLD_LD;
                        s_q        <= dir_set;
                        r_q        <= !dir_set;
                        q_shadow_q <= dir_set;
                        if (conflict && (conflict_cnt_q != {CNT_W{1'b1}})) begin
                            conflict_cnt_q <= conflict_cnt_q + 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        s_q <= 1'b0;
                        r_q <= 1'b0;
                        if (GAP_CYC > 0) begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready    = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.s            = s_q;
    assign bus.r            = r_q;
    assign bus.q_shadow     = q_shadow_q;
    assign bus.conflict_cnt = conflict_cnt_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_sr_cmd_driver.sv
// Bench for sr_cmd_driver: a default build (HOLD 2, GAP 1, clear wins) and a fast build
// (HOLD 1, GAP 0, set wins) driven with identical commands and checked against a countdown model.
module tb_sr_cmd_driver;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sr_cmd_if #(.CNT_W(8)) b0();
  sr_cmd_if #(.CNT_W(8)) b1();
  logic [1:0] st0, st1;

  sr_cmd_driver #(.HOLD_CYC(2), .GAP_CYC(1), .RST_PRIORITY(1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .state_o(st0));
  sr_cmd_driver #(.HOLD_CYC(1), .GAP_CYC(0), .RST_PRIORITY(0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .state_o(st1));

  int checks = 0;
  int errors = 0;

  // Reference model: per build, cycles of pulse left and cycles of busy left.
  int   m_pulse [2];
  int   m_busy  [2];
  int   m_cnt   [2];
  bit   m_q     [2];
  bit   m_dir   [2];
  logic [0:0] exp_q[$];
  bit   prev_act0;

  function automatic int hold_of(int k); return (k == 0) ? 2 : 1; endfunction
  function automatic int gap_of(int k);  return (k == 0) ? 1 : 0; endfunction
  function automatic bit clr_wins(int k); return (k == 0); endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 0; m_busy[k] = 0; m_cnt[k] = 0; m_q[k] = 0; m_dir[k] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_edge(input bit v, input bit s, input bit c);
    bit dir;
    for (int k = 0; k < 2; k++) begin
      if (v && m_busy[k] == 0) begin
        if (s || c) begin
          dir = (s && c) ? !clr_wins(k) : s;
          m_q[k] = dir;
          m_dir[k] = dir;
          m_pulse[k] = hold_of(k);
          m_busy[k] = hold_of(k) + gap_of(k);
          if (s && c && m_cnt[k] < 255) m_cnt[k]++;
          if (k == 0) exp_q.push_back(dir);
        end
      end else begin
        if (m_pulse[k] > 0) m_pulse[k]--;
        if (m_busy[k] > 0) m_busy[k]--;
      end
    end
  endtask

  task automatic compare_all();
    int es0, er0, es1, er1;
    logic [0:0] d;
    es0 = (m_pulse[0] > 0 && m_dir[0]) ? 1 : 0;
    er0 = (m_pulse[0] > 0 && !m_dir[0]) ? 1 : 0;
    es1 = (m_pulse[1] > 0 && m_dir[1]) ? 1 : 0;
    er1 = (m_pulse[1] > 0 && !m_dir[1]) ? 1 : 0;
    chk("s0", b0.s, es0);
    chk("r0", b0.r, er0);
    chk("ready0", b0.req_ready, (m_busy[0] == 0) ? 1 : 0);
    chk("busy0", b0.busy, (m_busy[0] > 0) ? 1 : 0);
    chk("qsh0", b0.q_shadow, m_q[0]);
    chk("cnt0", b0.conflict_cnt, m_cnt[0]);
    chk("s1", b1.s, es1);
    chk("r1", b1.r, er1);
    chk("ready1", b1.req_ready, (m_busy[1] == 0) ? 1 : 0);
    chk("busy1", b1.busy, (m_busy[1] > 0) ? 1 : 0);
    chk("qsh1", b1.q_shadow, m_q[1]);
    chk("cnt1", b1.conflict_cnt, m_cnt[1]);
    chk("not11_0", (b0.s && b0.r) ? 1 : 0, 0);
    chk("not11_1", (b1.s && b1.r) ? 1 : 0, 0);
    // Scoreboard: every pulse start on build 0 must match the oldest accepted direction.
    if ((b0.s || b0.r) && !prev_act0) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pulse", 1, 0);
      end else begin
        d = exp_q.pop_front();
        chk("sb_dir", b0.s, d);
      end
    end
    prev_act0 = b0.s || b0.r;
  endtask

  task automatic drive(input bit v, input bit s, input bit c);
    b0.req_valid = v; b0.req_set = s; b0.req_clr = c;
    b1.req_valid = v; b1.req_set = s; b1.req_clr = c;
  endtask

  task automatic step(input bit v, input bit s, input bit c);
    drive(v, s, c);
    @(posedge clk);
    model_edge(v, s, c);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    drive(0, 0, 0);
    rst = 1'b0;
    model_reset();
    prev_act0 = 0;
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    bit v, s, c;
    bit es, er, erdy, eq;
    int ecnt;
  } vec_t;
  vec_t vecs[17];
  int pulses1;

  initial begin
    vecs[0]  = '{1,1,0, 1,0,0,1, 0};
    vecs[1]  = '{1,0,1, 1,0,0,1, 0};
    vecs[2]  = '{1,0,1, 0,0,0,1, 0};
    vecs[3]  = '{1,0,1, 0,0,1,1, 0};
    vecs[4]  = '{1,0,1, 0,1,0,0, 0};
    vecs[5]  = '{0,0,0, 0,1,0,0, 0};
    vecs[6]  = '{0,0,0, 0,0,0,0, 0};
    vecs[7]  = '{0,0,0, 0,0,1,0, 0};
    vecs[8]  = '{1,1,1, 0,1,0,0, 1};
    vecs[9]  = '{0,0,0, 0,1,0,0, 1};
    vecs[10] = '{0,0,0, 0,0,0,0, 1};
    vecs[11] = '{0,0,0, 0,0,1,0, 1};
    vecs[12] = '{1,0,0, 0,0,1,0, 1};
    vecs[13] = '{1,1,0, 1,0,0,1, 1};
    vecs[14] = '{0,0,0, 1,0,0,1, 1};
    vecs[15] = '{0,0,0, 0,0,0,1, 1};
    vecs[16] = '{0,0,0, 0,0,1,1, 1};

    drive(0, 0, 0);
    do_reset();
    chk("rst_ready0", b0.req_ready, 1);
    chk("rst_qsh0", b0.q_shadow, 0);
    chk("rst_cnt0", b0.conflict_cnt, 0);

    // Fixed vectors on the default build, including back-to-back set/clr and a no-op.
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].v, vecs[i].s, vecs[i].c);
      chk($sformatf("vec%0d_s", i), b0.s, vecs[i].es);
      chk($sformatf("vec%0d_r", i), b0.r, vecs[i].er);
      chk($sformatf("vec%0d_rdy", i), b0.req_ready, vecs[i].erdy);
      chk($sformatf("vec%0d_q", i), b0.q_shadow, vecs[i].eq);
      chk($sformatf("vec%0d_cnt", i), b0.conflict_cnt, vecs[i].ecnt);
    end

    // Fast build: valid held with conflicting commands accepts every 2 cycles, set wins.
    do_reset();
    pulses1 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1);
      if (b1.s) pulses1++;
    end
    chk("fast_pulses", pulses1, 4);
    chk("fast_qsh", b1.q_shadow, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("fast_noop_ready", b1.req_ready, 1);
    chk("fast_noop_s", b1.s, 0);

    // Reset mid-pulse must drop s without a clock edge.
    do_reset();
    step(1, 1, 0);
    chk("mid_s_before", b0.s, 1);
    #2 rst = 1'b0;
    #1 chk("mid_s_async", b0.s, 0);
    chk("mid_s_async1", b1.s, 0);
    drive(0, 0, 0);
    model_reset();
    prev_act0 = 0;
    @(negedge clk);
    compare_all();
    rst = 1'b1;
    step(0, 0, 0);
    chk("mid_ready", b0.req_ready, 1);
    chk("mid_qsh", b0.q_shadow, 0);

    // Conflict saturation: more than 256 accepted conflicts on both builds.
    do_reset();
    for (int i = 0; i < 260 * 4; i++) step(1, 1, 1);
    chk("sat_cnt0", b0.conflict_cnt, 8'hFF);
    chk("sat_cnt1", b1.conflict_cnt, 8'hFF);
    chk("sat_qsh0", b0.q_shadow, 0);

    // Randomized commands against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    step(0, 0, 0);
    chk("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
